// File: rtl/mod_reduce.sv
// Sequential restoring divider: reduces the multiplier product modulo a small
// modulus, one quotient bit per clock, with a start/done handshake.
module mod_reduce #(
    parameter int DW = 12,
    parameter int MW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [MW-1:0] modulus,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] remainder,
    output logic [DW-1:0] quotient,
    output logic          div_err
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, ERR} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] dq_q;     // dividend shifts out the top while quotient bits fill the bottom
    logic [MW-1:0] mod_q;
    logic [MW:0]   prem_q;
    logic [CW-1:0] cnt_q;

    logic [MW+1:0] wide;
    logic [MW:0]   diff;
    logic [MW:0]   prem_nx;
    logic [DW-1:0] dq_nx;
    logic          qbit;
    logic          last;

    assign wide    = {prem_q, dq_q[DW-1]};
    assign qbit    = (wide >= {2'b00, mod_q});
    assign diff    = (MW+1)'(wide - {2'b00, mod_q});
    assign prem_nx = qbit ? diff : wide[MW:0];
    assign dq_nx   = {dq_q[DW-2:0], qbit};
    assign last    = (cnt_q == CW'(1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (modulus != '0) ? CALC : ERR;
            CALC:    if (last) state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_q      <= '0;
            mod_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            div_err   <= 1'b0;
            remainder <= '0;
            quotient  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_err <= 1'b0;
                        if (modulus != '0) begin
                            dq_q   <= dividend;
                            mod_q  <= modulus;
                            prem_q <= '0;
                            cnt_q  <= CW'(DW);
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_nx;
                    dq_q   <= dq_nx;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last) begin
                        remainder <= prem_nx[MW-1:0];
                        quotient  <= dq_nx;
                        done      <= 1'b1;
                    end
                end
                ERR: begin
                    done      <= 1'b1;
                    div_err   <= 1'b1;
                    quotient  <= '1;
                    remainder <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
